pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RV32I pipeline. It takes the decoded fields of the ID-stage instruction and keeps its own shadow copies of the EX, MEM and WB stage control fields. From these it drives stall, flush and bubble controls, the EX-stage operand forwarding selects, and the data-memory request handshake. It sits beside the decoder and pipeline registers and owns no datapath.

---
 rtl/rv_pkg.sv | 64 ++++++
 rtl/forward_unit.sv | 38 +++
 rtl/pipeline_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the pipeline hazard controller.
//   - opcode values (inst[6:2]) and opcode classification helpers
//   - forwarding select encodings
//   - data-memory handshake FSM states
//   - shadow-stage record layouts
package rv_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_WAIT,
    M_DONE
  } mem_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] opcode;
    logic [4:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writes_rd;
  } wb_stage_t;

  function automatic logic uses_rs1(input logic [4:0] opc);
    return (opc == OPC_JALR)  || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_OPIMM)  || (opc == OPC_OP);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
  endfunction

  function automatic logic writes_rd(input logic [4:0] opc, input logic [4:0] rd);
    return (opc != OPC_BRANCH) && (opc != OPC_STORE) && (rd != 5'd0);
  endfunction

  function automatic logic is_ldst(input logic [4:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one EX-stage source register.
// Purely combinational: compares the source index against the MEM and WB
// shadow destinations. MEM has priority over WB; a load in MEM cannot
// forward because its data is not available until writeback.
//   ex_valid       EX shadow holds a real instruction
//   src_used       the EX instruction reads this source
//   src_index      source register index
//   mem_*          MEM shadow: valid, writes_rd, is a load, rd
//   wb_*           WB shadow: valid, writes_rd, rd
//   fwd_sel        00 register file, 01 EX/MEM result, 10 MEM/WB writeback
module forward_unit
  import rv_pkg::*;
(
  input  logic       ex_valid,
  input  logic       src_used,
  input  logic [4:0] src_index,
  input  logic       mem_valid,
  input  logic       mem_writes_rd,
  input  logic       mem_is_load,
  input  logic [4:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_writes_rd,
  input  logic [4:0] wb_rd,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_REG;
    if (ex_valid && src_used && (src_index != '0)) begin
      if (mem_valid && mem_writes_rd && !mem_is_load && (mem_rd == src_index)) begin
        fwd_sel = FWD_MEM;
      end else if (wb_valid && wb_writes_rd && (wb_rd == src_index)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Tracks shadow copies of the EX/MEM/WB control fields and drives stall,
// flush and bubble controls, EX forwarding selects and the data-memory
// request handshake. Owns no datapath.
//   clk, rst_n          clock; synchronous active-low reset
//   id_valid, id_*      decoded fields of the ID-stage instruction
//   ex_branch_taken     EX resolved a taken branch/jump
//   dmem_ack            data memory completed the current access
//   dmem_req            MEM-stage load/store request, held until acked
//   stall_if/id/ex      hold PC+IF/ID, ID/EX, EX/MEM
//   flush_ifid/idex     bubble into IF/ID, ID/EX
//   bubble_memwb        bubble into MEM/WB
//   fwd_a_sel/fwd_b_sel EX operand source selects
module pipeline_ctrl
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_opcode,
  input  logic [4:0] id_rs1_index,
  input  logic [4:0] id_rs2_index,
  input  logic [4:0] id_rd_index,
  input  logic       ex_branch_taken,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       bubble_memwb,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  ex_stage_t  ex_q;
  mem_stage_t mem_q;
  wb_stage_t  wb_q;
  mem_state_e mstate, mstate_d;

  logic       mem_ldst;
  logic       mem_stall;
  logic       load_use;
  logic       mem_writes;
  logic       mem_is_load;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign mem_ldst    = mem_q.valid && is_ldst(mem_q.opcode);
  assign mem_stall   = mem_ldst && (mstate != M_DONE);
  assign mem_writes  = writes_rd(mem_q.opcode, mem_q.rd);
  assign mem_is_load = (mem_q.opcode == OPC_LOAD);

  assign load_use = ex_q.valid && (ex_q.opcode == OPC_LOAD) && (ex_q.rd != '0) && id_valid &&
                    ((uses_rs1(id_opcode) && (id_rs1_index == ex_q.rd)) ||
                     (uses_rs2(id_opcode) && (id_rs2_index == ex_q.rd)));

  // Memory handshake FSM. dmem_req depends only on state and MEM shadow,
  // so there is no combinational path from dmem_ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstate <= M_IDLE;
    end else begin
      mstate <= mstate_d;
    end
  end

  always_comb begin
    mstate_d = mstate;
    dmem_req = 1'b0;
    unique case (mstate)
      M_IDLE: begin
        if (mem_ldst) begin
          dmem_req = 1'b1;
          mstate_d = dmem_ack ? M_DONE : M_WAIT;
        end
      end
      M_WAIT: begin
        dmem_req = mem_ldst;
        if (dmem_ack) begin
          mstate_d = M_DONE;
        end
      end
      M_DONE: begin
        mstate_d = M_IDLE;
      end
      default: begin
        mstate_d = M_IDLE;
      end
    endcase
    if (!rst_n) begin
      dmem_req = 1'b0;
    end
  end

  // Hazard priority: memory stall, then taken branch, then load-use.
  // While reset is held the pipeline registers are forced to bubbles.
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    bubble_memwb = 1'b0;
    if (!rst_n) begin
      flush_ifid   = 1'b1;
      flush_idex   = 1'b1;
      bubble_memwb = 1'b1;
    end else if (mem_stall) begin
      stall_if     = 1'b1;
      stall_id     = 1'b1;
      stall_ex     = 1'b1;
      bubble_memwb = 1'b1;
    end else if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (load_use) begin
      stall_if   = 1'b1;
      flush_idex = 1'b1;
    end
  end

  // Shadow stages advance exactly as the real pipeline registers do
  // under the controls driven above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      if (!stall_id) begin
        if (flush_idex) begin
          ex_q <= '0;
        end else begin
          ex_q.valid  <= id_valid;
          ex_q.opcode <= id_opcode;
          ex_q.rd     <= id_rd_index;
          ex_q.rs1    <= id_rs1_index;
          ex_q.rs2    <= id_rs2_index;
        end
      end
      if (!stall_ex) begin
        mem_q.valid  <= ex_q.valid;
        mem_q.opcode <= ex_q.opcode;
        mem_q.rd     <= ex_q.rd;
      end
      if (bubble_memwb) begin
        wb_q <= '0;
      end else begin
        wb_q.valid     <= mem_q.valid;
        wb_q.rd        <= mem_q.rd;
        wb_q.writes_rd <= mem_writes;
      end
    end
  end

  forward_unit u_fwd_a (
    .ex_valid      (ex_q.valid),
    .src_used      (uses_rs1(ex_q.opcode)),
    .src_index     (ex_q.rs1),
    .mem_valid     (mem_q.valid),
    .mem_writes_rd (mem_writes),
    .mem_is_load   (mem_is_load),
    .mem_rd        (mem_q.rd),
    .wb_valid      (wb_q.valid),
    .wb_writes_rd  (wb_q.writes_rd),
    .wb_rd         (wb_q.rd),
    .fwd_sel       (fwd_a_raw)
  );

  forward_unit u_fwd_b (
    .ex_valid      (ex_q.valid),
    .src_used      (uses_rs2(ex_q.opcode)),
    .src_index     (ex_q.rs2),
    .mem_valid     (mem_q.valid),
    .mem_writes_rd (mem_writes),
    .mem_is_load   (mem_is_load),
    .mem_rd        (mem_q.rd),
    .wb_valid      (wb_q.valid),
    .wb_writes_rd  (wb_q.writes_rd),
    .wb_rd         (wb_q.rd),
    .fwd_sel       (fwd_b_raw)
  );

  assign fwd_a_sel = rst_n ? fwd_a_raw : FWD_REG;
  assign fwd_b_sel = rst_n ? fwd_b_raw : FWD_REG;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver issues one cycle of
// inputs and pushes the hand-computed output vector; the monitor pops and
// compares on the falling edge of each cycle.
// Vector layout: {dmem_req, stall_if, stall_id, stall_ex, flush_ifid,
//                 flush_idex, bubble_memwb, fwd_a_sel, fwd_b_sel}
module tb_pipeline_ctrl;

  localparam logic [4:0] L_LOAD   = 5'b00000;
  localparam logic [4:0] L_STORE  = 5'b01000;
  localparam logic [4:0] L_OPIMM  = 5'b00100;
  localparam logic [4:0] L_OP     = 5'b01100;
  localparam logic [4:0] L_BRANCH = 5'b11000;

  localparam logic [10:0] E_IDLE  = 11'h000;
  localparam logic [10:0] E_RST   = 11'h070;
  localparam logic [10:0] E_MSTL  = 11'h790;
  localparam logic [10:0] E_LU    = 11'h220;
  localparam logic [10:0] E_BR    = 11'h060;
  localparam logic [10:0] E_FA_M  = 11'h004;
  localparam logic [10:0] E_FB_M  = 11'h001;
  localparam logic [10:0] E_FA_W  = 11'h008;
  localparam logic [10:0] E_FAB_W = 11'h00A;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_opcode, id_rs1_index, id_rs2_index, id_rd_index;
  logic       ex_branch_taken, dmem_ack;
  logic       dmem_req, stall_if, stall_id, stall_ex;
  logic       flush_ifid, flush_idex, bubble_memwb;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  typedef struct {
    string       name;
    logic [10:0] vec;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  pipeline_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs1_index    (id_rs1_index),
    .id_rs2_index    (id_rs2_index),
    .id_rd_index     (id_rd_index),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ack        (dmem_ack),
    .dmem_req        (dmem_req),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .bubble_memwb    (bubble_memwb),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel)
  );

  always #5 clk = ~clk;

  task automatic step(input string nm, input logic r, input logic v,
                      input logic [4:0] opc, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd,
                      input logic br, input logic ack, input logic [10:0] exp_vec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = r;
    id_valid        = v;
    id_opcode       = opc;
    id_rs1_index    = rs1;
    id_rs2_index    = rs2;
    id_rd_index     = rd;
    ex_branch_taken = br;
    dmem_ack        = ack;
    e.name = nm;
    e.vec  = exp_vec;
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic br, input logic ack,
                      input logic [10:0] exp_vec);
    step(nm, 1'b1, 1'b0, L_OPIMM, 5'd0, 5'd0, 5'd0, br, ack, exp_vec);
  endtask

  task automatic ins(input string nm, input logic [4:0] opc, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd, input logic br,
                     input logic ack, input logic [10:0] exp_vec);
    step(nm, 1'b1, 1'b1, opc, rs1, rs2, rd, br, ack, exp_vec);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [10:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {dmem_req, stall_if, stall_id, stall_ex, flush_ifid, flush_idex,
               bubble_memwb, fwd_a_sel, fwd_b_sel};
        checks++;
        if (got !== e.vec) begin
          errors++;
          $display("FAIL %s: got %b required %b", e.name, got, e.vec);
        end
      end
    end
  end

  // Driver
  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rs1_index = '0;
    id_rs2_index = '0; id_rd_index = '0; ex_branch_taken = 1'b0; dmem_ack = 1'b0;

    step("reset0", 1'b0, 1'b0, L_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RST);
    step("reset1", 1'b0, 1'b0, L_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RST);

    // back-to-back and one-NOP-gap dependency
    ins ("add_x5",     L_OP,    5'd1, 5'd2, 5'd5, 1'b0, 1'b0, E_IDLE);
    ins ("sub_dep",    L_OP,    5'd5, 5'd1, 5'd6, 1'b0, 1'b0, E_IDLE);
    idle("fwd_mem",                              1'b0, 1'b0, E_FA_M);
    ins ("add_x5_b",   L_OP,    5'd1, 5'd2, 5'd5, 1'b0, 1'b0, E_IDLE);
    ins ("nop",        L_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);
    ins ("sub_dep_b",  L_OP,    5'd5, 5'd1, 5'd6, 1'b0, 1'b0, E_IDLE);
    idle("fwd_wb",                               1'b0, 1'b0, E_FA_W);
    idle("drain1",                               1'b0, 1'b0, E_IDLE);

    // load-use, ack tied high
    ins ("lw_x7",      L_LOAD,  5'd1, 5'd0, 5'd7, 1'b0, 1'b1, E_IDLE);
    ins ("loaduse",    L_OP,    5'd7, 5'd7, 5'd8, 1'b0, 1'b1, E_LU);
    ins ("lu_mstall",  L_OP,    5'd7, 5'd7, 5'd8, 1'b0, 1'b1, E_MSTL);
    ins ("lu_release", L_OP,    5'd7, 5'd7, 5'd8, 1'b0, 1'b1, E_IDLE);
    idle("lu_fwd_wb",                            1'b0, 1'b1, E_FAB_W);
    idle("drain2",                               1'b0, 1'b0, E_IDLE);

    // store with ack 3 cycles after request rises
    ins ("sw",         L_STORE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, E_IDLE);
    idle("sw_ex",                                1'b0, 1'b0, E_IDLE);
    idle("memwait0",                             1'b0, 1'b0, E_MSTL);
    idle("memwait1",                             1'b0, 1'b0, E_MSTL);
    idle("memwait2",                             1'b0, 1'b0, E_MSTL);
    idle("memwait_ack",                          1'b0, 1'b1, E_MSTL);
    idle("mem_done",                             1'b0, 1'b0, E_IDLE);

    // taken branch coinciding with load-use
    ins ("lw_x9",      L_LOAD,  5'd1, 5'd0, 5'd9,  1'b0, 1'b0, E_IDLE);
    ins ("br_and_lu",  L_OP,    5'd9, 5'd0, 5'd10, 1'b1, 1'b0, E_BR);
    idle("br_lw_stall",                          1'b0, 1'b1, E_MSTL);
    idle("br_lw_done",                           1'b0, 1'b0, E_IDLE);

    // branch held in EX during a memory stall
    ins ("lw_x11",     L_LOAD,   5'd1, 5'd0, 5'd11, 1'b0, 1'b0, E_IDLE);
    ins ("beq",        L_BRANCH, 5'd1, 5'd2, 5'd0,  1'b0, 1'b0, E_IDLE);
    idle("br_in_stall",                          1'b1, 1'b0, E_MSTL);
    idle("br_in_stall_ack",                      1'b1, 1'b1, E_MSTL);
    idle("br_after_done",                        1'b1, 1'b0, E_BR);

    // rd = x0 never creates a hazard or forward
    ins ("lw_x0",      L_LOAD,  5'd1, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);
    ins ("add_x0_src", L_OP,    5'd0, 5'd0, 5'd1, 1'b0, 1'b0, E_IDLE);
    idle("x0_ld_stall",                          1'b0, 1'b1, E_MSTL);
    idle("x0_done",                              1'b0, 1'b0, E_IDLE);

    // reset in the middle of M_WAIT, then a stray ack
    ins ("sw_b",       L_STORE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, E_IDLE);
    idle("sw_b_fwd_wb",                          1'b0, 1'b0, E_FA_W);
    idle("rstwait0",                             1'b0, 1'b0, E_MSTL);
    idle("rstwait1",                             1'b0, 1'b0, E_MSTL);
    step("rst_mid_wait", 1'b0, 1'b0, L_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RST);
    idle("late_ack",                             1'b0, 1'b1, E_IDLE);

    // MEM wins over WB on operand B; both WB on the next
    ins ("add_x14_a",   L_OP,   5'd1,  5'd2,  5'd14, 1'b0, 1'b0, E_IDLE);
    ins ("add_x14_b",   L_OP,   5'd3,  5'd4,  5'd14, 1'b0, 1'b0, E_IDLE);
    ins ("sub_x15",     L_OP,   5'd3,  5'd14, 5'd15, 1'b0, 1'b0, E_IDLE);
    ins ("mem_over_wb", L_OP,   5'd14, 5'd14, 5'd16, 1'b0, 1'b0, E_FB_M);
    idle("fwd_both_wb",                          1'b0, 1'b0, E_FAB_W);
    idle("drain3",                               1'b0, 1'b0, E_IDLE);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
